// File: rtl/bcd_display_engine.sv
// Sequential double-dabble binary-to-BCD converter with N-digit 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros and floats the sign.
module bcd_display_engine #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int SD = (DATA_W * 30103 + 99999) / 100000 + 1;
  localparam int SW = (SD > DIGITS) ? SD : DIGITS;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   val_q, mag;
  logic                sm_q, neg_int;
  logic [4*SW-1:0]     scr, scr_adj;
  logic [CW-1:0]       cnt;
  logic                ovf_c;
  logic [4*DIGITS-1:0] bcd_c;
  logic [7*DIGITS-1:0] seg_c;
  int                  avail, msd;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (cnt == '0) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < SW; i++)
      if (scr[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
  end

  // One digit is reserved for the sign, so fewer digits hold magnitude.
  always_comb begin
    ovf_c = 1'b0;
    avail = neg_int ? DIGITS - 1 : DIGITS;
    for (int i = 0; i < SW; i++)
      if (i >= avail && scr[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    bcd_c = scr[4*DIGITS-1:0];
    if (neg_int) bcd_c[4*DIGITS-1 -: 4] = 4'd0;
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_c[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++)
      seg_c[7*i +: 7] = seg7(bcd_c[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < DIGITS; i++) begin
      if (i > msd) seg_c[7*i +: 7] = BLANK;
      if (neg_int && i == msd + 1) seg_c[7*i +: 7] = DASH;
    end
`else
    if (neg_int) seg_c[7*DIGITS-1 -: 7] = DASH;
`endif
    if (ovf_c) seg_c = {DIGITS{DASH}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg      <= '1;
      val_q    <= '0;
      sm_q     <= 1'b0;
      mag      <= '0;
      neg_int  <= 1'b0;
      scr      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          val_q <= value;
          sm_q  <= signed_mode;
          busy  <= 1'b1;
        end
        LOAD: begin
          if (sm_q && val_q[DATA_W-1]) begin
            mag     <= -val_q;
            neg_int <= 1'b1;
          end else begin
            mag     <= val_q;
            neg_int <= 1'b0;
          end
          scr <= '0;
          cnt <= CW'(DATA_W - 1);
        end
        SHIFT: begin
          {scr, mag} <= {scr_adj[4*SW-2:0], mag, 1'b0};
          cnt        <= cnt - 1'b1;
        end
        FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          neg      <= neg_int;
          overflow <= ovf_c;
          bcd      <= bcd_c;
          seg      <= seg_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_engine.sv
// Directed self-checking bench for bcd_display_engine (DATA_W=32, DIGITS=8).
// Seg expectations are nibble codes: 0-9 numerals, A dash, B blank.
module tb_bcd_display_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        signed_mode = 1'b0;
  logic        busy, done, neg, overflow;
  logic [31:0] bcd;
  logic [55:0] seg;

  int pass_cnt = 0;
  int total = 0;

  bcd_display_engine #(.DATA_W(32), .DIGITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .neg(neg), .overflow(overflow), .bcd(bcd), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] mk_seg(input logic [31:0] c);
    logic [55:0] s;
    for (int i = 0; i < 8; i++) begin
      case (c[4*i +: 4])
        4'h0: s[7*i +: 7] = 7'b1000000;
        4'h1: s[7*i +: 7] = 7'b1111001;
        4'h2: s[7*i +: 7] = 7'b0100100;
        4'h3: s[7*i +: 7] = 7'b0110000;
        4'h4: s[7*i +: 7] = 7'b0011001;
        4'h5: s[7*i +: 7] = 7'b0010010;
        4'h6: s[7*i +: 7] = 7'b0000010;
        4'h7: s[7*i +: 7] = 7'b1111000;
        4'h8: s[7*i +: 7] = 7'b0000000;
        4'h9: s[7*i +: 7] = 7'b0010000;
        4'hA: s[7*i +: 7] = 7'b0111111;
        default: s[7*i +: 7] = 7'b1111111;
      endcase
    end
    return s;
  endfunction

  // Starts at a negedge, returns at the negedge where done is seen.
  task automatic convert(input logic [31:0] v, input logic sm);
    int n;
    value = v;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL accept v=%h: busy=%b done=%b want 1 0", v, busy, done);
    else pass_cnt++;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (done !== 1'b1 && n < 100);
    total++;
    if (n !== 34)
      $display("FAIL latency v=%h: got %0d edges want 34", v, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, neg, overflow} !== 4'b0 || bcd !== 32'h0 || seg !== '1)
      $display("FAIL reset: busy=%b done=%b neg=%b ovf=%b bcd=%h seg=%h want 0 0 0 0 0 all-ones",
               busy, done, neg, overflow, bcd, seg);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conversions();
    logic [31:0] vv [11] = '{32'd12345678, 32'd100000000, 32'hFFFFFB2E,
      32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd99999999,
      32'hFF676981, 32'hFF676980, 32'd7};
    logic sv [11] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
    logic [31:0] eb [11] = '{32'h12345678, 32'h00000000, 32'h00001234,
      32'h07483648, 32'h0, 32'h00000001, 32'h94967295, 32'h99999999,
      32'h09999999, 32'h00000000, 32'h00000007};
    logic en [11] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
    logic eo [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0};
`ifdef LEADING_ZERO_BLANK_EN
    logic [31:0] ec [11] = '{32'h12345678, 32'hAAAAAAAA, 32'hBBBA1234,
      32'hAAAAAAAA, 32'hBBBBBBB0, 32'hBBBBBBA1, 32'hAAAAAAAA, 32'h99999999,
      32'hA9999999, 32'hAAAAAAAA, 32'hBBBBBBB7};
`else
    logic [31:0] ec [11] = '{32'h12345678, 32'hAAAAAAAA, 32'hA0001234,
      32'hAAAAAAAA, 32'h00000000, 32'hA0000001, 32'hAAAAAAAA, 32'h99999999,
      32'hA9999999, 32'hAAAAAAAA, 32'h00000007};
`endif
    for (int k = 0; k < 11; k++) begin
      convert(vv[k], sv[k]);
      total++;
      if (bcd !== eb[k])
        $display("FAIL bcd v=%h sm=%b: got %h want %h", vv[k], sv[k], bcd, eb[k]);
      else pass_cnt++;
      total++;
      if (neg !== en[k] || overflow !== eo[k])
        $display("FAIL flags v=%h: neg=%b ovf=%b want %b %b",
                 vv[k], neg, overflow, en[k], eo[k]);
      else pass_cnt++;
      total++;
      if (seg !== mk_seg(ec[k]))
        $display("FAIL seg v=%h: got %h want %h", vv[k], seg, mk_seg(ec[k]));
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total++;
      if (done !== 1'b0 || bcd !== eb[k])
        $display("FAIL hold v=%h: done=%b bcd=%h want 0 %h", vv[k], done, bcd, eb[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    value = 32'd12345678;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      start = (c == 5 || c == 20);
      value = start ? 32'd999 : 32'd12345678;
      signed_mode = start;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        ndone++;
        total++;
        if (c !== 34 || bcd !== 32'h12345678)
          $display("FAIL busy_start: done at %0d bcd=%h want 34 12345678", c, bcd);
        else pass_cnt++;
      end
    end
    total++;
    if (ndone !== 1)
      $display("FAIL busy_start_count: got %0d dones want 1", ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    value = 32'd4321;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, neg, overflow} !== 4'b0 || bcd !== 32'h0 || seg !== '1)
      $display("FAIL abort_reset: busy=%b done=%b bcd=%h seg=%h want 0 0 0 all-ones",
               busy, done, bcd, seg);
    else pass_cnt++;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0)
      $display("FAIL abort_quiet: got %0d active cycles want 0", ndone);
    else pass_cnt++;
    convert(32'd5, 1'b0);
    total++;
    if (bcd !== 32'h5 || seg !== mk_seg(32'h00000005)
`ifdef LEADING_ZERO_BLANK_EN
        && seg !== mk_seg(32'hBBBBBBB5)
`endif
       )
      $display("FAIL abort_after: bcd=%h seg=%h want 5", bcd, seg);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    convert(32'd42, 1'b0);
    convert(32'hFFFFFFD6, 1'b1);
    total++;
    if (bcd !== 32'h00000042 || neg !== 1'b1 || overflow !== 1'b0)
      $display("FAIL back_to_back: bcd=%h neg=%b ovf=%b want 42 1 0",
               bcd, neg, overflow);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_conversions();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/bcd_display_engine.md
Name: bcd_display_engine

Overview:
- Sequential binary-to-BCD converter with a multi-digit 7-segment driver.
- Generalises the fixed 4-digit unsigned output path to N digits, an arbitrary input width, signed display and overflow indication.
- Sits between the register file read port used by the output instruction and the HEX display pins.
- Converts using shift-add-3 (double dabble), one bit per clock, and presents all digits atomically.

Parameters:
- DATA_W, 32, width of the input value.
- DIGITS, 8, number of displayed digits (1..10).

Ports:
- clk  input  1  system clock (divided CPU clock)
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only when busy=0
- value  input  DATA_W  binary value to display, latched on accepted start
- signed_mode  input  1  treat value as two's complement, latched with value
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; outputs updated this cycle
- neg  output  1  displayed value is negative
- overflow  output  1  magnitude does not fit the available digits
- bcd  output  4*DIGITS  digit i in bcd[4i+3:4i]; digit 0 is the units digit
- seg  output  7*DIGITS  digit i in seg[7i+6:7i], bit 7i = segment a … bit 7i+6 = segment g; active-low

Behaviour:
- Interface (decided): single clock clk; reset is synchronous and active-high.
- Reset values: busy=0, done=0, neg=0, overflow=0, bcd=0, seg all ones (blank). The FSM returns to IDLE.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
- IDLE: start=1 latches value and signed_mode, then goes to LOAD. busy rises on the same edge.
- LOAD:
  - If signed_mode=1 and value[DATA_W-1]=1: magnitude = two's-complement negation (unsigned, DATA_W bits) and neg_int=1.
  - Otherwise magnitude = value and neg_int=0.
  - Clears the scratch BCD register. Goes to SHIFT with the bit counter at DATA_W-1.
- Scratch BCD register: holds ceil(DATA_W*log10(2))+1 digits, independent of DIGITS.
- SHIFT, each cycle:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, magnitude} shifts left by 1.
  - Exactly DATA_W cycles, then goes to FINISH.
- FINISH:
  - avail = DIGITS-1 if neg_int, else DIGITS.
  - overflow_int = any scratch digit at index >= avail is nonzero.
  - On the next edge: done=1, busy=0, and neg, overflow, bcd, seg are registered together. The FSM returns to IDLE.
- Latency: done is high exactly DATA_W+2 edges after the edge that accepted start (34 for the default).
- bcd contents: low DIGITS scratch digits. When neg=1, digit DIGITS-1 is forced to 0.
- seg encoding, active-low, pattern {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, blank=1111111
- Normal display: each digit shows its numeral. If neg=1, digit DIGITS-1 shows '-'.
- Overflow display: every digit shows '-'. overflow=1, bcd still holds the truncated low digits.
- Edge cases:
  - Most-negative input: its magnitude is treated as unsigned.
  - signed_mode=0 with MSB set: displayed as a large positive value.
- start while busy=1: ignored, with no effect on the conversion in progress.
- start in the same cycle as done: accepted, since busy is already low.
- Outputs hold their last values until the next done. They are never partially updated.
- reset mid-conversion: conversion is aborted, no done pulse, all outputs take their reset values.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In FINISH, zero digits above the most significant nonzero digit are shown blank in seg. Digit 0 is never blanked.
  - When neg=1, '-' is placed in the digit immediately left of the most significant nonzero digit instead of digit DIGITS-1.
  - The bcd output is unaffected.
  - Overflow display is unchanged (all '-').
- Undefined: all digits are always shown, leading zeros included; sign stays in digit DIGITS-1.

Test Plan:
- Reset held 3 cycles -> busy=0, done=0, neg=0, overflow=0, bcd=0, seg=all ones.
- Unsigned: value=12345678, signed_mode=0, start 1 cycle -> done pulse exactly 34 edges later; bcd=32'h12345678, overflow=0, seg digit0=0000000 (8), digit7=1111001 (1).
- Unsigned overflow: value=100000000 -> overflow=1, every seg digit=0111111, bcd=32'h00000000.
- Signed: value=32'hFFFFFB2E (-1234), signed_mode=1 -> neg=1, bcd=32'h00001234, digit7 '-', digits 4-6 show 0. With LEADING_ZERO_BLANK_EN: digit4 '-', digits 5-7 blank.
- Signed overflow and blanking:
  - value=32'h80000000, signed_mode=1 -> neg=1, overflow=1, all digits '-'.
  - value=0 with LEADING_ZERO_BLANK_EN -> digit0 shows 0, digits 1-7 blank.
- Control hazards:
  - start pulsed at cycles 5 and 20 after the first start -> only one done, result from the first value.
  - reset asserted at cycle 10 of a conversion -> no done, outputs at reset values; a new start afterwards converts normally.
